serial_subtractor_ctrl: RTL and testbench



---
 rtl/serial_subtractor_ctrl.sv | 117 +++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one difference/borrow cell, LSB first,
// sequenced by an IDLE/RUN/DONE FSM with a start/busy/done handshake.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a0;
    logic             b0;
    logic             d;
    logic             bnext;
    logic             last;

    // Single difference/borrow cell plus the result with d entering at the MSB
    always_comb begin
        a0      = a_sh[0];
        b0      = b_sh[0];
        d       = a0 ^ b0 ^ borrow;
        bnext   = (~a0 & b0) | (~(a0 ^ b0) & borrow);
        res_nxt = WIDTH'({d, res} >> 1);
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand/result shifting; visible results only change on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a_in;
                        b_sh   <= b_in;
                        res    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res    <= res_nxt;
                    borrow <= bnext;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff <= res_nxt;
                        bout <= bnext;
                        zero <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomised and directed bench for serial_subtractor_ctrl (WIDTH=8 and WIDTH=1)
// against a transaction-timeline model built on plain modular arithmetic.
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       st [2];
    logic [7:0] av [2];
    logic [7:0] bv [2];

    logic       busy8, done8, bout8, zero8;
    logic [7:0] diff8;
    logic       busy1, done1, bout1, zero1;
    logic [0:0] diff1;

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st[0]), .a_in(av[0]), .b_in(bv[0]),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .a_in(av[1][0:0]), .b_in(bv[1][0:0]),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1)
    );

    function automatic int w_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    function automatic logic [7:0] mask_of(input int k);
        return (k == 0) ? 8'hFF : 8'h01;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a request accepted while idle yields done exactly w cycles later,
    // then one idle-returning cycle; results are (a-b) mod 2^w and a<b.
    logic       pend [2];
    int         age  [2];
    logic [7:0] ma   [2];
    logic [7:0] mb   [2];
    logic [7:0] ed   [2];
    logic       eb   [2];
    logic       ez   [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] <= 1'b0;
                age[k]  <= 0;
                ed[k]   <= 8'h00;
                eb[k]   <= 1'b0;
                ez[k]   <= 1'b0;
            end else if (pend[k]) begin
                age[k] <= age[k] + 1;
                if (age[k] == w_of(k) - 1) begin
                    ed[k] <= 8'(ma[k] - mb[k]) & mask_of(k);
                    eb[k] <= (ma[k] < mb[k]);
                    ez[k] <= ((8'(ma[k] - mb[k]) & mask_of(k)) == 8'h00);
                end
                if (age[k] == w_of(k)) pend[k] <= 1'b0;
            end else if (st[k]) begin
                pend[k] <= 1'b1;
                age[k]  <= 0;
                ma[k]   <= av[k] & mask_of(k);
                mb[k]   <= bv[k] & mask_of(k);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy8", 32'(busy8), 32'(pend[0] && age[0] < 8));
            chk("done8", 32'(done8), 32'(pend[0] && age[0] == 8));
            chk("diff8", 32'(diff8), 32'(ed[0]));
            chk("bout8", 32'(bout8), 32'(eb[0]));
            chk("zero8", 32'(zero8), 32'(ez[0]));
            chk("busy1", 32'(busy1), 32'(pend[1] && age[1] < 1));
            chk("done1", 32'(done1), 32'(pend[1] && age[1] == 1));
            chk("diff1", 32'(diff1), 32'(ed[1][0]));
            chk("bout1", 32'(bout1), 32'(eb[1]));
            chk("zero1", 32'(zero1), 32'(ez[1]));
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] xd, input logic xb, input logic xz);
        int n;
        @(negedge clk);
        st[0] = 1'b1; av[0] = a; bv[0] = b;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("lit_latency8", 32'(n), 32'd8);
        chk("lit_diff8", 32'(diff8), 32'(xd));
        chk("lit_bout8", 32'(bout8), 32'(xb));
        chk("lit_zero8", 32'(zero8), 32'(xz));
        repeat (3) @(negedge clk);
        chk("lit_hold8", 32'(diff8), 32'(xd));
    endtask

    task automatic run1(input logic a, input logic b, input logic xd, input logic xb);
        @(negedge clk);
        st[1] = 1'b1; av[1] = {7'b0, a}; bv[1] = {7'b0, b};
        @(negedge clk);
        st[1] = 1'b0;
        chk("lit_busy1", 32'(busy1), 32'd1);
        @(negedge clk);
        chk("lit_done1", 32'(done1), 32'd1);
        chk("lit_diff1", 32'(diff1), 32'(xd));
        chk("lit_bout1", 32'(bout1), 32'(xb));
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; av[k] = 8'h00; bv[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("lit_rst_busy", 32'(busy8), 32'd0);
        chk("lit_rst_done", 32'(done8), 32'd0);
        chk("lit_rst_diff", 32'(diff8), 32'd0);
        chk("lit_rst_bz", 32'({bout8, zero8}), 32'd0);
        rst = 1'b0;
        check_en = 1'b1;

        run8(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
        run8(8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
        run8(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1);
        run8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

        // start held high with changing operands: one result per 10 cycles
        @(negedge clk);
        st[0] = 1'b1; av[0] = 8'($urandom); bv[0] = 8'($urandom);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) n++;
            av[0] = 8'($urandom); bv[0] = 8'($urandom);
        end
        st[0] = 1'b0;
        chk("lit_held_dones", 32'(n), 32'd4);
        repeat (12) @(negedge clk);

        // reset in the middle of a run
        @(negedge clk);
        st[0] = 1'b1; av[0] = 8'd200; bv[0] = 8'd13;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("lit_abort_busy", 32'(busy8), 32'd0);
        chk("lit_abort_out", 32'({done8, diff8, bout8, zero8}), 32'd0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("lit_abort_nodone", 32'(n), 32'd0);
        run8(8'd200, 8'd13, 8'd187, 1'b0, 1'b0);

        run1(1'b0, 1'b0, 1'b0, 1'b0);
        run1(1'b0, 1'b1, 1'b1, 1'b1);
        run1(1'b1, 1'b0, 1'b1, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            st[0] = ($urandom % 3) == 0;
            st[1] = ($urandom % 2) == 0;
            av[0] = 8'($urandom); bv[0] = 8'($urandom);
            av[1] = 8'($urandom); bv[1] = 8'($urandom);
            rst   = ($urandom % 97) == 0;
        end
        rst = 1'b0; st[0] = 1'b0; st[1] = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
